imm_unpacker: RTL and testbench

IMM_UNPACKER -- requirements
Module: imm_unpacker

---
 rtl/imm_unpacker.sv | 59 +++++
 tb/tb_imm_unpacker.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/imm_unpacker.sv
// imm_unpacker: assembles 4 bytes (LSB first) into a word, exposing the I-type immediate and a 17-bit split sum.
// Optional frame counter port/logic enabled by defining IMM_UNPACKER_CNT_EN.
module imm_unpacker #(
  parameter bit SEXT = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] inst_data_o,
  output logic [31:0] iimm_o,
`ifdef IMM_UNPACKER_CNT_EN
  output logic [7:0]  frame_cnt_o,
`endif
  output logic [16:0] sum_o
);
  typedef enum logic {COLLECT, FULL} state_t;
  state_t      r_state, w_next;
  logic [1:0]  r_idx;
  logic [23:0] r_buf;
  logic [31:0] r_word;
  logic        w_take, w_done;
  assign w_take = in_valid_i & in_ready_o;
  assign w_done = out_valid_o & out_ready_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= COLLECT;
    else         r_state <= w_next;
  always_comb
    w_next = (r_state == COLLECT) ? ((w_take && r_idx == 2'd3) ? FULL : COLLECT)
                                  : (w_done ? COLLECT : FULL);
  always_comb begin
    in_ready_o  = (r_state == COLLECT);
    out_valid_o = (r_state == FULL);
  end
  // partial bytes live in r_buf so the outputs keep the last completed word while collecting
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_idx  <= 2'd0;
      r_buf  <= 24'd0;
      r_word <= 32'd0;
    end else if (w_take) begin
      r_idx <= r_idx + 2'd1;
      if (r_idx == 2'd3) r_word <= {in_data_i, r_buf};
      else               r_buf[8*r_idx +: 8] <= in_data_i;
    end
  assign inst_data_o = r_word;
  assign iimm_o      = SEXT ? {{20{r_word[31]}}, r_word[31:20]} : {20'd0, r_word[31:20]};
  assign sum_o       = {2'b0, r_word[14:0]} + {1'b0, r_word[31:16]};
`ifdef IMM_UNPACKER_CNT_EN
  logic [7:0] r_cnt;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni)     r_cnt <= 8'd0;
    else if (w_done) r_cnt <= r_cnt + 8'd1;
  assign frame_cnt_o = r_cnt;
`endif
endmodule

// File: tb/tb_imm_unpacker.sv
// tb_imm_unpacker: randomized byte-stream driver with a word scoreboard; checks both SEXT builds side by side.
module tb_imm_unpacker;
  logic clk = 1'b0, rst_ni = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [7:0] in_data_i = 8'd0;
  logic in_ready_o, out_valid_o, in_ready_z, out_valid_z;
  logic [31:0] inst_data_o, iimm_o, inst_z, iimm_z;
  logic [16:0] sum_o, sum_z;
`ifdef IMM_UNPACKER_CNT_EN
  logic [7:0] frame_cnt_o, cnt_z;
`endif
  int checks = 0, failures = 0, rdy_mode = 0, exp_cnt = 0;
  bit pend = 0;
  logic [31:0] q[$];

  imm_unpacker #(.SEXT(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .inst_data_o(inst_data_o), .iimm_o(iimm_o),
`ifdef IMM_UNPACKER_CNT_EN
    .frame_cnt_o(frame_cnt_o),
`endif
    .sum_o(sum_o));
  imm_unpacker #(.SEXT(1'b0)) dut_z (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_ready_o(in_ready_z), .out_valid_o(out_valid_z), .out_ready_i(out_ready_i),
    .inst_data_o(inst_z), .iimm_o(iimm_z),
`ifdef IMM_UNPACKER_CNT_EN
    .frame_cnt_o(cnt_z),
`endif
    .sum_o(sum_z));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: immediate is the top 12 bits, arithmetic or logical shift
  function automatic logic [31:0] ref_iimm(input logic [31:0] w, input bit s);
    return s ? 32'($signed(w) >>> 20) : (w >> 20);
  endfunction
  function automatic logic [16:0] ref_sum(input logic [31:0] w);
    return 17'(w % 32'd32768) + 17'(w / 32'd65536);
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready_i = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
  end

  // monitor: compares the presented word against the scoreboard head every cycle it is valid
  always @(negedge clk) begin
    if (!rst_ni) begin
      exp_cnt = 0;
      pend = 0;
    end else begin
      chk("ready_vs_valid", in_ready_o, !out_valid_o);
      chk("ready_z", in_ready_z, !out_valid_z);
      if (pend) chk("valid_held", out_valid_o, 1);
`ifdef IMM_UNPACKER_CNT_EN
      chk("frame_cnt", frame_cnt_o, exp_cnt);
`endif
      if (out_valid_o) begin
        if (q.size() == 0) chk("spurious_valid", out_valid_o, 0);
        else begin
          chk("inst_data", inst_data_o, q[0]);
          chk("iimm_sext", iimm_o, ref_iimm(q[0], 1'b1));
          chk("sum", sum_o, ref_sum(q[0]));
          chk("valid_z", out_valid_z, 1);
          chk("iimm_zext", iimm_z, ref_iimm(q[0], 1'b0));
          chk("sum_z", sum_z, ref_sum(q[0]));
          if (out_ready_i) begin
            void'(q.pop_front());
            exp_cnt = (exp_cnt + 1) % 256;
          end
        end
      end
      pend = out_valid_o && !out_ready_i;
    end
  end

  // n bytes of w, LSB first; gap: 0 random idles, 1 alternate valid, 2 back-to-back
  task automatic send(input logic [31:0] w, input int n, input int gap);
    for (int b = 0; b < n; b++) begin
      int g, t;
      g = (gap == 0) ? int'($urandom_range(0, 2)) : (gap == 1) ? 1 : 0;
      repeat (g) begin
        in_valid_i = 1'b0;
        in_data_i = 8'($urandom);
        @(posedge clk); #1;
      end
      in_valid_i = 1'b1;
      in_data_i = w[8*b +: 8];
      t = 0;
      while (!in_ready_o && t < 200) begin @(posedge clk); #1; t++; end
      if (t == 200) chk("ready_timeout", in_ready_o, 1);
      @(posedge clk); #1;
      if (b == 3) begin
        q.push_back(w);
        chk("latency", out_valid_o, 1);
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst_ni = 1'b0;
    in_valid_i = 1'b0;
    q.delete();
    @(negedge clk);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_inst", inst_data_o, 0);
    chk("rst_iimm", iimm_o, 0);
    chk("rst_iimm_z", iimm_z, 0);
    chk("rst_sum", sum_o, 0);
`ifdef IMM_UNPACKER_CNT_EN
    chk("rst_cnt", frame_cnt_o, 0);
`endif
    @(posedge clk); #1 rst_ni = 1'b1;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    logic [31:0] hold_w;
    do_reset();
    rdy_mode = 1;
    send(32'hFFF00000, 4, 2);
    send(32'hFFFF7FFF, 4, 2);
    drain();
    chk("carry_bit", sum_o[16], 1);
    chk("carry_sum", sum_o, 17'h17FFE);
    // stall in FULL with a byte offered; the monitor checks stability and no consumption
    rdy_mode = 2;
    hold_w = $urandom;
    send(hold_w, 4, 2);
    in_valid_i = 1'b1;
    in_data_i = 8'hAA;
    repeat (5) begin @(posedge clk); #1; end
    chk("hold_ready", in_ready_o, 0);
    chk("hold_valid", out_valid_o, 1);
    chk("hold_inst", inst_data_o, hold_w);
    in_valid_i = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < 40; i++) send($urandom, 4, 0);
    for (int i = 0; i < 10; i++) send($urandom, 4, 1);
    drain();
    send($urandom, 2, 0);
    do_reset();
    rdy_mode = 1;
    send(32'h04030201, 4, 2);
    drain();
    chk("after_rst_word", inst_data_o, 32'h04030201);
    rdy_mode = 2;
    send($urandom, 4, 0);
    @(posedge clk); #1;
    do_reset();
    rdy_mode = 0;
    send(32'h80000123, 4, 0);
    drain();
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < 257; i++) send($urandom, 4, 2);
    drain();
    @(negedge clk);
`ifdef IMM_UNPACKER_CNT_EN
    chk("cnt_wrap", frame_cnt_o, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
